// File: rtl/bram_delay_ctrl.sv
// Address/priming controller that turns a single-port BRAM into a programmable delay line.
// Zero-latency ram_we from ce, registered address/status; cfg_ready is low only while held in IDLE after reset.
module bram_delay_ctrl #(
    parameter int ADDR_BITS     = 10,
    parameter int LATENCY       = 2,
    parameter int DEFAULT_DELAY = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic [ADDR_BITS:0]   cfg_delay,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_we,
    output logic                 primed,
    output logic [ADDR_BITS:0]   cur_delay
);

    localparam int DW = ADDR_BITS + 1;
    localparam logic [ADDR_BITS:0] D_MIN  = DW'(LATENCY + 1);
    localparam logic [ADDR_BITS:0] D_MAX  = DW'((1 << ADDR_BITS) + LATENCY);
    localparam logic [ADDR_BITS:0] D_RST  = DW'(DEFAULT_DELAY);
    localparam logic [ADDR_BITS:0] LAT_P1 = DW'(LATENCY + 1);

    generate
        if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
            $error("bram_delay_ctrl: LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [ADDR_BITS:0]     fill_q, fill_d;
    logic [ADDR_BITS:0]     delay_q, delay_d;
    logic                   err_q, err_d;
    logic [1:0]             rst_sync;

    logic [ADDR_BITS:0]     wrap_pt;
    logic                   at_wrap;
    logic                   fill_done;
    logic                   cfg_in_range;
    logic                   cfg_accept;

    // Release is seen by the FSM only after two flops; assertion is still immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // Wrap compare kept at full width so D near the top of the range is not aliased.
    assign wrap_pt      = delay_q - LAT_P1;
    assign at_wrap      = ({1'b0, addr_q} == wrap_pt);
    assign fill_done    = (fill_q == (delay_q - DW'(1)));
    assign cfg_in_range = (cfg_delay >= D_MIN) && (cfg_delay <= D_MAX);
    assign cfg_accept   = cfg_valid && cfg_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fill_d  = fill_q;
        delay_d = delay_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_sync[1]) begin
                    state_d = PRIME;
                    addr_d  = '0;
                    fill_d  = '0;
                end
            end
            PRIME, RUN: begin
                if (cfg_accept && cfg_in_range) begin
                    // A new delay overrides any wrap or fill completion this cycle.
                    state_d = PRIME;
                    delay_d = cfg_delay;
                    addr_d  = '0;
                    fill_d  = '0;
                end else begin
                    err_d = cfg_accept;
                    if (ce) begin
                        addr_d = at_wrap ? '0 : addr_q + 1'b1;
                        if (state_q == PRIME) begin
                            fill_d = fill_q + 1'b1;
                            if (fill_done) begin
                                state_d = RUN;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                fill_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            fill_q  <= '0;
            delay_q <= D_RST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fill_q  <= fill_d;
            delay_q <= delay_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready = (state_q == PRIME) || (state_q == RUN);
    assign ram_we    = ce && cfg_ready;
    assign primed    = (state_q == RUN);
    assign ram_addr  = addr_q;
    assign cur_delay = delay_q;
    assign cfg_err   = err_q;

    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state_q inside {IDLE, PRIME, RUN});
    a_addr_bound: assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, addr_q} <= wrap_pt);
    a_fill_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fill_q <= delay_q);

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Randomised bench for bram_delay_ctrl with a BRAM model and a ce-cycle-count reference model.
module tb_bram_delay_ctrl;

    localparam int AB  = 4;
    localparam int LAT = 2;
    localparam int DD  = 8;

    logic          clk = 1'b0;
    logic          rst_n, ce, cfg_valid, cfg_ready, cfg_err, ram_we, primed;
    logic [AB:0]   cfg_delay, cur_delay;
    logic [AB-1:0] ram_addr;

    always #5 clk = ~clk;

    bram_delay_ctrl #(.ADDR_BITS(AB), .LATENCY(LAT), .DEFAULT_DELAY(DD)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .cfg_delay(cfg_delay), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .ram_addr(ram_addr), .ram_we(ram_we),
        .primed(primed), .cur_delay(cur_delay)
    );

    // Read-first single-port RAM, two-stage ce-gated read pipeline.
    logic [7:0] din, r1, r2;
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= din;
        if (ce) begin
            r1 <= mem[ram_addr];
            r2 <= r1;
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference: k = ce cycles since priming began; hist = din of each of those cycles.
    int         k;
    int         m_delay;
    logic       m_err;
    logic [7:0] hist [$];

    function automatic logic [12:0] exp_vec();
        int a;
        a = k % (m_delay - LAT);
        return {4'(a), (k >= m_delay), 5'(m_delay), m_err, ce, 1'b1};
    endfunction

    function automatic logic [12:0] act_vec();
        return {ram_addr, primed, cur_delay, cfg_err, ram_we, cfg_ready};
    endfunction

    task automatic drive(input logic c, input logic v, input logic [4:0] d);
        ce        = c;
        cfg_valid = v;
        cfg_delay = d;
        din       = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic edge_upd();
        logic acc;
        @(posedge clk);
        acc   = 1'b0;
        m_err = 1'b0;
        if (cfg_valid) begin
            if (cfg_delay >= 5'(LAT + 1) && cfg_delay <= 5'((1 << AB) + LAT)) begin
                m_delay = int'(cfg_delay);
                k       = 0;
                hist.delete();
                acc     = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        if (!acc && ce) begin
            hist.push_back(din);
            k++;
        end
        #1;
    endtask

    task automatic release_and_wait(output int n);
        n     = 0;
        rst_n = 1'b1;
        while (n < 8) begin
            @(negedge clk);
            if (cfg_ready === 1'b1) break;
            @(posedge clk);
            #1;
            n++;
        end
        k       = 0;
        m_delay = DD;
        m_err   = 1'b0;
        hist.delete();
        edge_upd();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b1; ce = 1'b1; cfg_valid = 1'b0; cfg_delay = '0; din = '0;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (act_vec() !== {4'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals got=%h want=%h", act_vec(), {4'd0, 1'b0, 5'd8, 3'b000});
        end
        @(posedge clk); @(posedge clk); #1;
        release_and_wait(n);
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL reset_release_edges got=%0d want=3", n);
        end
    endtask

    task automatic test_continuous();
        logic       saw_wrap = 1'b0;
        logic [3:0] prev     = 4'd0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 5'd0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL cont_vec i=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
            if (k >= m_delay) begin
                total++;
                if (r2 !== hist[k - m_delay]) begin
                    bad++;
                    $display("FAIL cont_dout i=%0d got=%h want=%h", i, r2, hist[k - m_delay]);
                end
            end
            if (prev == 4'd5 && ram_addr == 4'd0) saw_wrap = 1'b1;
            prev = ram_addr;
            edge_upd();
        end
        total++;
        if (saw_wrap !== 1'b1) begin
            bad++;
            $display("FAIL cont_wrap got=0 want=1");
        end
    endtask

    task automatic test_ce_toggle();
        for (int i = 0; i < 25; i++) begin
            if (i == 0) drive(1'b1, 1'b1, 5'd8);
            else        drive(i[0], 1'b0, 5'd0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL toggle_vec i=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
            if (k >= m_delay) begin
                total++;
                if (r2 !== hist[k - m_delay]) begin
                    bad++;
                    $display("FAIL toggle_dout i=%0d got=%h want=%h", i, r2, hist[k - m_delay]);
                end
            end
            edge_upd();
        end
    endtask

    task automatic test_min_max();
        for (int i = 0; i < 55; i++) begin
            if (i == 0)       drive(1'b1, 1'b1, 5'd3);
            else if (i == 15) drive(1'b1, 1'b1, 5'd18);
            else if (i < 15)  drive(1'($urandom_range(0, 3) != 0), 1'b0, 5'd0);
            else              drive(1'b1, 1'b0, 5'd0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL minmax_vec i=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
            if (k >= m_delay) begin
                total++;
                if (r2 !== hist[k - m_delay]) begin
                    bad++;
                    $display("FAIL minmax_dout i=%0d got=%h want=%h", i, r2, hist[k - m_delay]);
                end
            end
            edge_upd();
        end
    endtask

    task automatic test_cfg_err();
        logic [4:0] bad_d [4] = '{5'd2, 5'd19, 5'd0, 5'd31};
        logic [3:0] addr0;
        drive(1'b1, 1'b1, 5'd8); edge_upd();
        for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b0, 5'd0); edge_upd(); end
        foreach (bad_d[j]) begin
            drive(1'b0, 1'b1, bad_d[j]);
            addr0 = ram_addr;
            edge_upd();
            drive(1'b0, 1'b0, 5'd0);
            total++;
            if ({cfg_err, cur_delay, primed, ram_addr} !== {1'b1, 5'd8, 1'b1, addr0}) begin
                bad++;
                $display("FAIL err_pulse d=%0d got=%h want=%h", bad_d[j],
                         {cfg_err, cur_delay, primed, ram_addr}, {1'b1, 5'd8, 1'b1, addr0});
            end
            edge_upd();
            drive(1'b0, 1'b0, 5'd0);
            total++;
            if (act_vec() !== exp_vec() || cfg_err !== 1'b0) begin
                bad++;
                $display("FAIL err_after d=%0d got=%h want=%h", bad_d[j], act_vec(), exp_vec());
            end
            edge_upd();
        end
    endtask

    task automatic test_collision();
        int n = 0;
        while ((k % 6) != 5 && n < 12) begin drive(1'b1, 1'b0, 5'd0); edge_upd(); n++; end
        drive(1'b1, 1'b1, 5'd8);
        total++;
        if (ram_addr !== 4'd5) begin
            bad++;
            $display("FAIL coll_at_wrap got=%0d want=5", ram_addr);
        end
        edge_upd();
        drive(1'b1, 1'b0, 5'd0);
        total++;
        if ({ram_addr, primed, cfg_ready} !== {4'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL coll_wrap_restart got=%h want=%h", {ram_addr, primed, cfg_ready}, 6'b000001);
        end
        edge_upd();
        n = 0;
        while (k != 7 && n < 12) begin drive(1'b1, 1'b0, 5'd0); edge_upd(); n++; end
        drive(1'b1, 1'b1, 5'd5);
        edge_upd();
        drive(1'b1, 1'b0, 5'd0);
        total++;
        if ({ram_addr, primed, cur_delay} !== {4'd0, 1'b0, 5'd5}) begin
            bad++;
            $display("FAIL coll_fill_restart got=%h want=%h", {ram_addr, primed, cur_delay}, {4'd0, 1'b0, 5'd5});
        end
        edge_upd();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 303; i++) begin
            if (i == 0)      drive(1'b1, 1'b1, 5'd10);
            else if (i == 1) drive(1'b0, 1'b1, 5'd2);
            else if (i == 2) drive(1'b1, 1'b1, 5'd7);
            else drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                       5'($urandom_range(3, 18)));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_vec i=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
            if (k >= m_delay) begin
                total++;
                if (r2 !== hist[k - m_delay]) begin
                    bad++;
                    $display("FAIL b2b_dout i=%0d got=%h want=%h", i, r2, hist[k - m_delay]);
                end
            end
            edge_upd();
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        drive(1'b1, 1'b1, 5'd12); edge_upd();
        while (!(k >= 12 && (k % 10) == 4) && n < 40) begin drive(1'b1, 1'b0, 5'd0); edge_upd(); n++; end
        total++;
        if ({primed, ram_addr} !== {1'b1, 4'd4}) begin
            bad++;
            $display("FAIL midrun_setup got=%h want=%h", {primed, ram_addr}, {1'b1, 4'd4});
        end
        ce = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (act_vec() !== {4'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midrun_reset got=%h want=%h", act_vec(), {4'd0, 1'b0, 5'd8, 3'b000});
        end
        @(posedge clk); #1;
        release_and_wait(n);
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL midrun_release_edges got=%0d want=3", n);
        end
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b0, 5'd0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reprime_vec i=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
            if (k >= m_delay) begin
                total++;
                if (r2 !== hist[k - m_delay]) begin
                    bad++;
                    $display("FAIL reprime_dout i=%0d got=%h want=%h", i, r2, hist[k - m_delay]);
                end
            end
            edge_upd();
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_ce_toggle();
        test_min_max();
        test_cfg_err();
        test_collision();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_delay_ctrl.md
BRAM_DELAY_CTRL -- requirements
Module: bram_delay_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_BITS, default 10, giving the RAM address width.
REQ-002 The module SHALL have parameter LATENCY, default 2, giving the RAM read latency; only the values 1 and 2 are legal.
REQ-003 The module SHALL have parameter DEFAULT_DELAY, default 1024, giving the delay in clocks loaded at reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port ce, input, 1 bit: clock enable; the delay line advances only on cycles with ce=1.
REQ-007 The module SHALL have port cfg_delay, input, ADDR_BITS+1 bits: the requested delay in clocks.
REQ-008 The module SHALL have port cfg_valid, input, 1 bit: a configuration request is present.
REQ-009 The module SHALL have port cfg_ready, output, 1 bit: the controller can accept a configuration this cycle.
REQ-010 The module SHALL have port cfg_err, output, 1 bit: a one-cycle pulse flagging a rejected out-of-range request.
REQ-011 The module SHALL have port ram_addr, output, ADDR_BITS bits: the single-port RAM address.
REQ-012 The module SHALL have port ram_we, output, 1 bit: the RAM write enable.
REQ-013 The module SHALL have port primed, output, 1 bit: the RAM dout equals din delayed by cur_delay ce-cycles.
REQ-014 The module SHALL have port cur_delay, output, ADDR_BITS+1 bits: the delay currently in force.

Function
REQ-015 The legal delay range SHALL be LATENCY+1 <= D <= 2^ADDR_BITS+LATENCY.
REQ-016 The wrap point SHALL be W = D-LATENCY-1, computed in ADDR_BITS+1 bits; no truncation is permitted before comparison.
REQ-017 The FSM SHALL have states IDLE, PRIME and RUN; there SHALL be no other reachable state.
REQ-018 In IDLE, the FSM SHALL move to PRIME on the first clock after reset release, regardless of ce, with cur_delay=DEFAULT_DELAY.
REQ-019 The address counter SHALL behave as follows in PRIME/RUN with ce=1: ram_addr <= (ram_addr==W) ? 0 : ram_addr+1.
REQ-020 The address counter SHALL hold its value when ce=0.
REQ-021 ram_we SHALL equal ce in PRIME/RUN (combinational from ce) and SHALL be 0 in IDLE.
REQ-022 The fill counter SHALL be cleared on PRIME entry and SHALL increment on each ce=1 cycle in PRIME.
REQ-023 When the fill count reaches D (the D-th ce cycle), the FSM SHALL go PRIME->RUN and set primed=1 on the next edge.
REQ-024 primed SHALL be 1 only in RUN.
REQ-025 cfg_ready SHALL be 1 in PRIME and RUN and 0 in IDLE.
REQ-026 A request is accepted on cfg_valid & cfg_ready; the controller SHALL take no action on cfg_valid while cfg_ready=0.
REQ-027 An accepted in-range request SHALL, on the next edge: set cur_delay=cfg_delay, ram_addr=0, fill=0, primed=0, state=PRIME.
REQ-028 An accepted out-of-range request SHALL pulse cfg_err=1 for exactly one cycle and leave state, ram_addr, cur_delay and primed unchanged.
REQ-029 Acceptance SHALL be independent of ce.
REQ-030 When an accepted request coincides with a wrap or with fill completion, the configuration action SHALL take priority.
REQ-031 A request equal to cur_delay SHALL still restart priming.
REQ-032 Back-to-back requests on consecutive cycles SHALL each be evaluated; the last valid one wins.

Reset
REQ-033 Asserting rst_n=0 at any time, including mid-PRIME or mid-RUN, SHALL immediately force: state=IDLE, ram_addr=0, ram_we=0, primed=0, cfg_ready=0, cfg_err=0, cur_delay=DEFAULT_DELAY, fill=0.
REQ-034 Reset release SHALL be synchronised to clk through a 2-flop synchroniser before the FSM leaves IDLE.

Verification (ADDR_BITS=4, LATENCY=2, DEFAULT_DELAY=8)
REQ-035 The bench SHALL cover: reset release, ce=1 continuous -> ram_addr cycles 0..5 and wraps to 0; primed rises after the 8th ce cycle in PRIME; RAM dout equals din from 8 cycles earlier.
REQ-036 The bench SHALL cover: ce toggling 1,0,1,0 -> ram_addr and fill advance only on ce=1; primed after 8 ce-high cycles; ram_we mirrors ce.
REQ-037 The bench SHALL cover: cfg_delay=3 (minimum) accepted in RUN -> W=0, ram_addr stays 0, primed after 3 ce cycles, output delay 3; then cfg_delay=18 (maximum) -> ram_addr wraps at 15, primed after 18 cycles.
REQ-038 The bench SHALL cover: cfg_delay=2 and cfg_delay=19 -> cfg_err one-cycle pulse each; cur_delay stays 8; primed and ram_addr undisturbed.
REQ-039 The bench SHALL cover: a request accepted on the same cycle as ram_addr==W and as fill completion -> ram_addr=0, primed=0, state PRIME.
REQ-040 The bench SHALL cover: rst_n pulled low mid-RUN with ram_addr=4 -> all outputs at reset values before the next clk edge; re-priming uses D=8.
